// File: rtl/slot_round_ctrl.sv
// Slot-machine round sequencer: spin edge -> bet latch -> RNG spin/settle -> evaluate -> one bank command.
// Optional macro PARTIAL_WIN_EN pays bet_r on exactly three equal digits.
module slot_round_ctrl #(
    parameter int SPIN_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_BAL       = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spin,
    input  logic        b1,
    input  logic        b10,
    input  logic        b50,
    input  logic        b100,
    input  logic [3:0]  randNum1,
    input  logic [3:0]  randNum2,
    input  logic [3:0]  randNum3,
    input  logic [3:0]  randNum4,
    input  logic [26:0] balance,
    output logic        rng_run,
    output logic        apply,
    output logic        credit,
    output logic [26:0] amount,
    output logic        win,
    output logic        reject,
    output logic        busy,
    output logic        game_over,
    output logic [15:0] rounds
);

    typedef enum logic [2:0] {IDLE, SPIN, SETTLE, EVAL, APPLY, LOCKED} state_t;

    localparam logic [26:0] MAX_BAL_W   = 27'(MAX_BAL);
    localparam logic [15:0] SPIN_LOAD   = 16'(SPIN_CYCLES - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

    state_t      state;
    logic        spin_q;
    logic        lock_r;
    logic [15:0] cnt;
    logic [26:0] bet_r;
    logic [26:0] bet;
    logic        req;

    logic        all_eq;
    logic [26:0] headroom;
    logic [26:0] double_bet;
    logic        pay_credit;
    logic        pay_win;
    logic        pay_lock;
    logic [26:0] pay_amount;

    assign req = spin & ~spin_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        bet = '0;
        if (b100)      bet = 27'd100;
        else if (b50)  bet = 27'd50;
        else if (b10)  bet = 27'd10;
        else if (b1)   bet = 27'd1;
    end

    always_comb begin
        all_eq     = (randNum1 == randNum2) && (randNum2 == randNum3) && (randNum3 == randNum4);
        headroom   = (balance < MAX_BAL_W) ? (MAX_BAL_W - balance) : '0;
        double_bet = {bet_r[25:0], 1'b0};
        pay_credit = 1'b0;
        pay_win    = 1'b0;
        pay_lock   = 1'b0;
        pay_amount = '0;
        if (all_eq) begin
            pay_credit = 1'b1;
            pay_win    = 1'b1;
            pay_amount = (double_bet < headroom) ? double_bet : headroom;
        end
`ifdef PARTIAL_WIN_EN
        else if (((randNum1 == randNum2) && (randNum2 == randNum3)) ||
                 ((randNum1 == randNum2) && (randNum2 == randNum4)) ||
                 ((randNum1 == randNum3) && (randNum3 == randNum4)) ||
                 ((randNum2 == randNum3) && (randNum3 == randNum4))) begin
            pay_credit = 1'b1;
            pay_win    = 1'b1;
            pay_amount = (bet_r < headroom) ? bet_r : headroom;
        end
`endif
        else begin
            pay_amount = (bet_r < balance) ? bet_r : balance;
            // Taking the whole balance empties the bank: the game locks.
            pay_lock   = (bet_r >= balance);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            spin_q    <= 1'b0;
            lock_r    <= 1'b0;
            cnt       <= '0;
            bet_r     <= '0;
            rng_run   <= 1'b0;
            apply     <= 1'b0;
            credit    <= 1'b0;
            amount    <= '0;
            win       <= 1'b0;
            reject    <= 1'b0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            rounds    <= '0;
        end else begin
            spin_q <= spin;
            reject <= 1'b0;
            apply  <= 1'b0;
            credit <= 1'b0;
            amount <= '0;
            win    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (bet == '0 || bet > balance) begin
                            reject <= 1'b1;
                        end else begin
                            bet_r   <= bet;
                            cnt     <= SPIN_LOAD;
                            rng_run <= 1'b1;
                            busy    <= 1'b1;
                            state   <= SPIN;
                        end
                    end
                end
                SPIN: begin
                    if (cnt == '0) begin
                        rng_run <= 1'b0;
                        cnt     <= SETTLE_LOAD;
                        state   <= SETTLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) state <= EVAL;
                    else           cnt   <= cnt - 16'd1;
                end
                EVAL: begin
                    apply  <= 1'b1;
                    credit <= pay_credit;
                    amount <= pay_amount;
                    win    <= pay_win;
                    lock_r <= pay_lock;
                    rounds <= rounds + 16'd1;
                    state  <= APPLY;
                end
                APPLY: begin
                    if (lock_r) begin
                        game_over <= 1'b1;
                        state     <= LOCKED;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                LOCKED: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slot_round_ctrl.sv
// Scoreboard bench for slot_round_ctrl: stimulus queues expected bank commands, a monitor checks each apply.
module tb_slot_round_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spin = 1'b0;
    logic        b1 = 1'b0, b10 = 1'b0, b50 = 1'b0, b100 = 1'b0;
    logic [3:0]  randNum1 = '0, randNum2 = '0, randNum3 = '0, randNum4 = '0;
    logic [26:0] balance = '0;
    logic        rng_run, apply, credit, win, reject, busy, game_over;
    logic [26:0] amount;
    logic [15:0] rounds;

    typedef struct {
        logic        credit;
        logic [26:0] amount;
        logic        win;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   exp_rounds = 0;

    slot_round_ctrl dut (
        .clk(clk), .rst(rst), .spin(spin),
        .b1(b1), .b10(b10), .b50(b50), .b100(b100),
        .randNum1(randNum1), .randNum2(randNum2), .randNum3(randNum3), .randNum4(randNum4),
        .balance(balance),
        .rng_run(rng_run), .apply(apply), .credit(credit), .amount(amount), .win(win),
        .reject(reject), .busy(busy), .game_over(game_over), .rounds(rounds)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every apply strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && apply) begin
            if (sb.size() == 0) begin
                check("unexpected_apply", 32'(apply), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("apply_cycle", 32'(cyc), 32'(e.cyc));
                check("credit", 32'(credit), 32'(e.credit));
                check("amount", 32'(amount), 32'(e.amount));
                check("win", 32'(win), 32'(e.win));
            end
        end
    end

    task automatic set_inputs(input logic [26:0] bal, input logic [3:0] sw,
                              input logic [3:0] d1, input logic [3:0] d2,
                              input logic [3:0] d3, input logic [3:0] d4);
        balance = bal;
        {b100, b50, b10, b1} = sw;
        {randNum1, randNum2, randNum3, randNum4} = {d1, d2, d3, d4};
    endtask

    // One accepted round; the spin rises at a negedge whose cycle is T, apply expected at T+20.
    task automatic round(input string name, input logic [26:0] bal, input logic [3:0] sw,
                         input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                         input logic [3:0] d4, input logic ec, input logic [26:0] ea,
                         input logic ew, input int hold);
        exp_t e;
        set_inputs(bal, sw, d1, d2, d3, d4);
        @(negedge clk);
        spin = 1'b1;
        e.credit = ec; e.amount = ea; e.win = ew; e.cyc = cyc + 20;
        sb.push_back(e);
        exp_rounds++;
        repeat (hold) @(negedge clk);
        spin = 1'b0;
        repeat (24) @(negedge clk);
        check({name, "_apply_seen"}, 32'(sb.size()), 32'd0);
        sb.delete();
        check({name, "_rounds"}, 32'(rounds), 32'(exp_rounds));
    endtask

    task automatic expect_reject(input string name, input logic exp_rej, input logic exp_busy);
        @(negedge clk);
        spin = 1'b1;
        @(negedge clk);
        check({name, "_reject"}, 32'(reject), 32'(exp_rej));
        check({name, "_busy"}, 32'(busy), 32'(exp_busy));
        spin = 1'b0;
        @(negedge clk);
        check({name, "_reject_gone"}, 32'(reject), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rng_run", 32'(rng_run), 32'd0);
        check("rst_outputs", 32'({apply, credit, win, reject, game_over}), 32'd0);
        check("rst_amount", 32'(amount), 32'd0);
        check("rst_rounds", 32'(rounds), 32'd0);
        rst = 1'b0;

        // Reset mid-SPIN aborts the round with no apply.
        set_inputs(27'd100, 4'b0010, 4'd3, 4'd3, 4'd3, 4'd3);
        @(negedge clk); spin = 1'b1;
        @(negedge clk); spin = 1'b0;
        repeat (4) @(negedge clk);
        check("midspin_busy", 32'(busy), 32'd1);
        check("midspin_rng_run", 32'(rng_run), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rng_run", 32'(rng_run), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_rounds", 32'(rounds), 32'd0);

        round("jackpot_b10", 27'd100, 4'b0010, 4'd3, 4'd3, 4'd3, 4'd3, 1'b1, 27'd20, 1'b1, 1);
        round("debit_b50", 27'd100, 4'b0100, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 27'd50, 1'b0, 1);
        check("debit_b50_idle", 32'(busy), 32'd0);

        set_inputs(27'd10, 4'b1000, 4'd0, 4'd0, 4'd0, 4'd0);
        expect_reject("bet_gt_bal", 1'b1, 1'b0);
        set_inputs(27'd10, 4'b0000, 4'd0, 4'd0, 4'd0, 4'd0);
        expect_reject("no_bet", 1'b1, 1'b0);

        round("clip_990", 27'd990, 4'b1000, 4'd7, 4'd7, 4'd7, 4'd7, 1'b1, 27'd10, 1'b1, 1);
        round("at_max", 27'd1000, 4'b0001, 4'd7, 4'd7, 4'd7, 4'd7, 1'b1, 27'd0, 1'b1, 1);
        round("held_spin", 27'd100, 4'b0001, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 27'd1, 1'b0, 100);
`ifdef PARTIAL_WIN_EN
        round("three_kind", 27'd100, 4'b0001, 4'd5, 4'd5, 4'd5, 4'd9, 1'b1, 27'd1, 1'b1, 1);
`else
        round("three_kind", 27'd100, 4'b0001, 4'd5, 4'd5, 4'd5, 4'd9, 1'b0, 27'd1, 1'b0, 1);
`endif
        round("bust", 27'd10, 4'b0010, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 27'd10, 1'b0, 1);
        check("bust_game_over", 32'(game_over), 32'd1);
        check("bust_busy", 32'(busy), 32'd1);
        expect_reject("locked_spin", 1'b0, 1'b1);
        check("locked_still", 32'(game_over), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
